// File: rtl/maj_pipe_net.sv
// Elastic pipeline of majority-of-three stages, each with a programmable
// complemented-edge mask, plus a saturating count of delivered results.
module maj_pipe_net #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_stage,
  input  logic [WIDTH-1:0] cfg_inv,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [WIDTH-1:0] r_inv  [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_srcVld;
  logic [WIDTH-1:0] w_next [DEPTH];
  logic             w_inAccept;
  logic             w_cfgInRange;
  logic             w_cfgOk;
  logic             w_outFire;

  // Bit i votes on v[i], v[i+1]^m[i] and v[i+2]; rotations supply the wrapped neighbours.
  function automatic logic [WIDTH-1:0] majStage(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    b = {v[0], v[WIDTH-1:1]} ^ m;
    c = {v[1:0], v[WIDTH-1:2]};
    return (v & b) | (v & c) | (b & c);
  endfunction

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    logic acc;
    acc   = out_ready;
    w_adv = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      acc      = acc | ~r_vld[s];
      w_adv[s] = acc;
    end
  end

  assign in_ready     = w_adv[0] & ~cfg_we & ~rst;
  assign w_inAccept   = in_valid & in_ready;
  assign w_outFire    = r_vld[DEPTH-1] & out_ready;
  assign w_cfgInRange = ({1'b0, cfg_stage} < (SW+1)'(DEPTH));
  assign w_cfgOk      = cfg_we & ~busy & w_cfgInRange;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_srcVld[s] = w_inAccept;
      assign w_next[s]   = majStage(in_data, r_inv[s]);
    end else begin : g_rest
      assign w_srcVld[s] = r_vld[s-1];
      assign w_next[s]   = majStage(r_data[s-1], r_inv[s]);
    end
  end

  // Data is captured only with a valid item so a stalled or drained stage keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        r_data[s] <= '0;
        r_inv[s]  <= '0;
      end
    end else begin
      r_err <= cfg_we & ~w_cfgOk;
      if (w_outFire && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      for (int s = 0; s < DEPTH; s++) begin
        if (w_adv[s]) begin
          r_vld[s] <= w_srcVld[s];
          if (w_srcVld[s]) begin
            r_data[s] <= w_next[s];
          end
        end
        if (w_cfgOk && (cfg_stage == SW'(s))) begin
          r_inv[s] <= cfg_inv;
        end
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign busy      = |r_vld;
  assign done_cnt  = r_cnt;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_maj_pipe_net.sv
// Self-checking bench for maj_pipe_net: vector table, directed corner cases
// and a randomized run against a behavioural scoreboard.
module tb_maj_pipe_net;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int D2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cfgWe, cfgErr, inValid, inReady, outValid, outReady, busy;
  logic [1:0]   cfgStage;
  logic [W-1:0] cfgInv, inData, outData;
  logic [15:0]  doneCnt;

  logic         cfgWe2, cfgErr2, inValid2, inReady2, outValid2, outReady2, busy2;
  logic [1:0]   cfgStage2;
  logic [W-1:0] cfgInv2, inData2, outData2;
  logic [1:0]   doneCnt2;

  maj_pipe_net #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfgWe), .cfg_stage(cfgStage), .cfg_inv(cfgInv),
    .cfg_err(cfgErr), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .busy(busy), .done_cnt(doneCnt)
  );

  maj_pipe_net #(.WIDTH(W), .DEPTH(D2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfgWe2), .cfg_stage(cfgStage2), .cfg_inv(cfgInv2),
    .cfg_err(cfgErr2), .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
    .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2),
    .busy(busy2), .done_cnt(doneCnt2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vecRecord_t;

  vecRecord_t   vecs [5];
  logic [W-1:0] modelInv [D];
  logic [W-1:0] expQ [$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: count votes per bit, majority means at least two of three.
  function automatic logic [W-1:0] refStage(input logic [W-1:0] v, input logic [W-1:0] m);
    logic [W-1:0] o;
    int votes;
    o = '0;
    for (int i = 0; i < W; i++) begin
      votes = int'(v[i]) + int'(v[(i + 1) % W] ^ m[i]) + int'(v[(i + 2) % W]);
      o[i]  = (votes >= 2);
    end
    return o;
  endfunction

  function automatic logic [W-1:0] refPipe(input logic [W-1:0] v, input int depth,
                                           input logic useMasks);
    logic [W-1:0] x;
    x = v;
    for (int s = 0; s < depth; s++) begin
      x = refStage(x, useMasks ? modelInv[s] : '0);
    end
    return x;
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    cfgWe = 1'b0; inValid = 1'b0; outReady = 1'b1;
    for (int s = 0; s < D; s++) modelInv[s] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] din);
    int waitCycles;
    waitCycles = 0;
    inValid = 1'b1;
    inData  = din;
    #1;
    while (!inReady && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("accept_ready", inReady, 1);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [W-1:0] exp, input int expLat);
    int lat;
    lat = 1;
    while (!outValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_valid"}, outValid, 1);
    checkOutput({name, "_data"}, outData, exp);
    if (expLat > 0) checkOutput({name, "_latency"}, lat, expLat);
    @(posedge clk); #1;
  endtask

  task automatic cfgWrite(input logic [1:0] stage, input logic [W-1:0] inv,
                          input logic expErr, input string name);
    cfgWe = 1'b1; cfgStage = stage; cfgInv = inv;
    #1;
    checkOutput({name, "_in_ready"}, inReady, 0);
    @(posedge clk); #1;
    cfgWe = 1'b0;
    checkOutput({name, "_err"}, cfgErr, expErr);
    if (!expErr) modelInv[stage] = inv;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] bpData [4];
    logic [1:0]   satExp [5];
    logic         prevStall;
    logic [W-1:0] prevData;
    logic         predReady;
    int           transfers;
    int           lat;

    rst = 1'b1;
    cfgWe = 1'b0; cfgStage = '0; cfgInv = '0; inValid = 1'b0; inData = '0; outReady = 1'b1;
    cfgWe2 = 1'b0; cfgStage2 = '0; cfgInv2 = '0; inValid2 = 1'b0; inData2 = '0; outReady2 = 1'b1;
    for (int s = 0; s < D; s++) modelInv[s] = '0;
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_out_data", outData, 0);
    checkOutput("rst_cfg_err", cfgErr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cnt", doneCnt, 0);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_in_ready2", inReady2, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs[0] = '{8'hFF, 8'hFF};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'h01, 8'h00};
    vecs[3] = '{8'h03, 8'h30};
    vecs[4] = '{8'hAA, 8'hAA};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].din);
      waitResult($sformatf("vec%0d", i), vecs[i].dout, D);
    end

    cfgWrite(2'd3, 8'hFF, 1'b0, "cfg_inv_on");
    applyStimulus(8'h03);
    waitResult("inv_on", 8'h48, D);
    cfgWrite(2'd3, 8'h00, 1'b0, "cfg_inv_off");
    applyStimulus(8'h03);
    waitResult("inv_off", 8'h30, D);

    applyReset();
    bpData = '{8'h01, 8'h03, 8'h07, 8'h0F};
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = bpData[i];
      #1;
      checkOutput($sformatf("bp_ready%0d", i), inReady, 1);
      @(posedge clk); #1;
    end
    inValid = 1'b1; inData = 8'h1F;
    #1;
    checkOutput("bp_full_ready", inReady, 0);
    checkOutput("bp_full_busy", busy, 1);
    checkOutput("bp_full_valid", outValid, 1);
    checkOutput("bp_cnt0", doneCnt, 0);
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_out_valid%0d", i), outValid, 1);
      checkOutput($sformatf("bp_out_data%0d", i), outData, refPipe(bpData[i], D, 1'b1));
      @(posedge clk); #1;
    end
    checkOutput("bp_drained_valid", outValid, 0);
    checkOutput("bp_drained_busy", busy, 0);
    checkOutput("bp_cnt4", doneCnt, 4);

    outReady = 1'b0;
    applyStimulus(8'h03);
    cfgWrite(2'd3, 8'hFF, 1'b1, "cfg_busy");
    @(posedge clk); #1;
    checkOutput("cfg_err_pulse_end", cfgErr, 0);
    outReady = 1'b1;
    waitResult("busy_item", 8'h30, -1);
    applyStimulus(8'h03);
    waitResult("mask_unchanged", 8'h30, D);

    cfgWe = 1'b1; cfgStage = 2'd3; cfgInv = 8'hFF;
    inValid = 1'b1; inData = 8'h03;
    #1;
    checkOutput("cfg_prio_in_ready", inReady, 0);
    @(posedge clk); #1;
    cfgWe = 1'b0; inValid = 1'b0;
    modelInv[3] = 8'hFF;
    checkOutput("cfg_prio_err", cfgErr, 0);
    checkOutput("cfg_prio_not_taken", busy, 0);
    applyStimulus(8'h03);
    waitResult("cfg_prio_mask", 8'h48, D);

    checkOutput("pre_rst_cnt", doneCnt, 7);
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = 8'(8'h03 << i);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    checkOutput("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", outValid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cnt", doneCnt, 0);
    checkOutput("mid_rst_ready", inReady, 0);
    @(posedge clk); #1;
    checkOutput("mid_rst_valid_edge", outValid, 0);
    rst = 1'b0;
    for (int s = 0; s < D; s++) modelInv[s] = '0;
    applyStimulus(8'h03);
    waitResult("after_rst", 8'h30, D);
    checkOutput("after_rst_cnt", doneCnt, 1);

    applyReset();
    for (int s = 0; s < D; s++) cfgWrite(2'(s), 8'($urandom), 1'b0, "rand_cfg");
    transfers = 0;
    prevStall = 1'b0;
    prevData  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prevStall) begin
        checkOutput("rand_stall_valid", outValid, 1);
        checkOutput("rand_stall_data", outData, prevData);
      end
      inValid  = ($urandom_range(0, 3) != 0);
      inData   = 8'($urandom);
      outReady = ($urandom_range(0, 2) != 0);
      #1;
      predReady = (expQ.size() < D) || outReady;
      checkOutput("rand_in_ready", inReady, predReady);
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("rand_spurious_out", outValid, 0);
        end else begin
          checkOutput("rand_data", outData, expQ.pop_front());
          transfers++;
        end
      end
      if (inValid && predReady) expQ.push_back(refPipe(inData, D, 1'b1));
      prevStall = outValid && !outReady;
      prevData  = outData;
      @(posedge clk); #1;
      checkOutput("rand_done_cnt", doneCnt, transfers);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < 40 && expQ.size() > 0; k++) begin
      if (outValid) checkOutput("drain_data", outData, expQ.pop_front());
      @(posedge clk); #1;
    end
    checkOutput("drain_queue_empty", expQ.size(), 0);
    checkOutput("drain_busy", busy, 0);

    cfgWe2 = 1'b1; cfgStage2 = 2'd3; cfgInv2 = 8'hFF;
    #1;
    checkOutput("oor_in_ready", inReady2, 0);
    @(posedge clk); #1;
    cfgWe2 = 1'b0;
    checkOutput("oor_err", cfgErr2, 1);
    satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      inValid2 = 1'b1; inData2 = 8'h03;
      #1;
      checkOutput($sformatf("sat_ready%0d", k), inReady2, 1);
      @(posedge clk); #1;
      inValid2 = 1'b0;
      lat = 1;
      while (!outValid2 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput($sformatf("sat_latency%0d", k), lat, D2);
      checkOutput($sformatf("sat_data%0d", k), outData2, refPipe(8'h03, D2, 1'b0));
      @(posedge clk); #1;
      checkOutput($sformatf("sat_cnt%0d", k), doneCnt2, satExp[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
